// File: rtl/memory_stage.sv
// Memory stage: branch resolution, aligned loads/stores over a req/ack port.
// Optional MEM_TIMEOUT_EN aborts a stuck access after TIMEOUT_CYCLES.
module memory_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] branch_addr_from_execution,
   input  logic [31:0] result_from_execution,
   input  logic [31:0] rs2_data_from_execution,
   input  logic        equal_from_execution,
   input  logic        greater_from_execution,
   input  logic        lesser_from_execution,
   input  logic [2:0]  funct3_from_execution,
   input  logic [4:0]  rd_from_execution,
   input  logic        write_reg_from_execution,
   input  logic        select_from_execution,
   input  logic        read_from_execution,
   input  logic        write_from_execution,
   input  logic        branch_from_execution,
   input  logic        u_branch_from_execution,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_from_memory,
   output logic        pc_src_from_memory,
   output logic [31:0] branch_target_from_memory,
   output logic [31:0] result_from_memory,
   output logic [31:0] mem_data_from_memory,
   output logic [4:0]  rd_from_memory,
   output logic        write_reg_from_memory,
   output logic        select_from_memory,
   output logic        misaligned_from_memory,
   output logic        bus_error_from_memory
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic        access, misaligned, go, abort, timeout_hit, cond;
   logic [1:0]  lo;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, load_ext;
   logic [31:0] addr_q, wdata_q, result_q, mem_data_q;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_l_q, rd_q;
   logic        we_q, wr_l_q, sel_l_q;
   logic        write_reg_q, select_q, misaligned_q;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign lo         = result_from_execution[1:0];
   assign access     = read_from_execution | write_from_execution;
   assign misaligned = access &
      (((funct3_from_execution[1:0] == 2'b01) & lo[0]) |
       ((funct3_from_execution[1:0] == 2'b10) & (lo != 2'b00)));
   assign go = access & ~misaligned;

   always_comb begin
      cond = 1'b0;
      unique case (funct3_from_execution)
         3'b000:          cond = equal_from_execution;
         3'b001:          cond = ~equal_from_execution;
         3'b100, 3'b110:  cond = lesser_from_execution;
         3'b101, 3'b111:  cond = ~lesser_from_execution;
         default:         cond = 1'b0;
      endcase
   end

   assign pc_src_from_memory = u_branch_from_execution |
                               (branch_from_execution & cond);
   assign branch_target_from_memory = branch_addr_from_execution;

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = rs2_data_from_execution;
      unique case (funct3_from_execution[1:0])
         2'b00: begin
            be_d    = 4'b0001 << lo;
            wdata_d = {4{rs2_data_from_execution[7:0]}};
         end
         2'b01: begin
            be_d    = lo[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{rs2_data_from_execution[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d           = state_q;
      stall_from_memory = 1'b0;
      abort             = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               stall_from_memory = 1'b1;
               state_d           = S_WAIT;
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               state_d = S_IDLE;
            end else if (timeout_hit) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               stall_from_memory = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Access fields are captured once so the bus sees them stable in WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         rd_l_q  <= '0;
         wr_l_q  <= 1'b0;
         sel_l_q <= 1'b0;
      end else if ((state_q == S_IDLE) && go) begin
         addr_q  <= result_from_execution;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= write_from_execution;
         f3_q    <= funct3_from_execution;
         rd_l_q  <= rd_from_execution;
         wr_l_q  <= write_reg_from_execution;
         sel_l_q <= select_from_execution;
      end
   end

   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;
   assign dmem_we    = we_q;
   assign dmem_req   = (state_q == S_WAIT) & ~abort;

   always_comb begin
      byte_sel = dmem_rdata[7:0];
      unique case (addr_q[1:0])
         2'b00: byte_sel = dmem_rdata[7:0];
         2'b01: byte_sel = dmem_rdata[15:8];
         2'b10: byte_sel = dmem_rdata[23:16];
         2'b11: byte_sel = dmem_rdata[31:24];
         default: ;
      endcase
      half_sel = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      unique case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q     <= '0;
         mem_data_q   <= '0;
         rd_q         <= '0;
         write_reg_q  <= 1'b0;
         select_q     <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= 1'b0;
         if (state_q == S_WAIT) begin
            if (dmem_ack) begin
               result_q    <= addr_q;
               mem_data_q  <= load_ext;
               rd_q        <= rd_l_q;
               write_reg_q <= wr_l_q;
               select_q    <= sel_l_q;
            end else begin
               write_reg_q <= 1'b0;
               if (abort) mem_data_q <= '0;
            end
         end else if (go) begin
            write_reg_q <= 1'b0;
         end else begin
            result_q     <= result_from_execution;
            mem_data_q   <= '0;
            rd_q         <= rd_from_execution;
            select_q     <= select_from_execution;
            write_reg_q  <= write_reg_from_execution & ~misaligned;
            misaligned_q <= misaligned;
         end
      end
   end

   assign result_from_memory     = result_q;
   assign mem_data_from_memory   = mem_data_q;
   assign rd_from_memory         = rd_q;
   assign write_reg_from_memory  = write_reg_q;
   assign select_from_memory     = select_q;
   assign misaligned_from_memory = misaligned_q;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] cnt_q;
   logic       bus_error_q;
   logic       unused_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         bus_error_q <= 1'b0;
      end else begin
         bus_error_q <= abort;
         if (state_q == S_IDLE) cnt_q <= '0;
         else if (!dmem_ack)    cnt_q <= cnt_q + 8'd1;
      end
   end

   assign timeout_hit = (state_q == S_WAIT) & ~dmem_ack &
                        (cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign bus_error_from_memory = bus_error_q;
   assign unused_in = greater_from_execution;
`else
   logic unused_in;
   assign timeout_hit           = 1'b0;
   assign bus_error_from_memory = 1'b0;
   assign unused_in = greater_from_execution ^ TIMEOUT_CYCLES[0];
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, branches, misalign, reset.
// Define MEM_TIMEOUT_EN to also exercise the bus timeout.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] branch_addr_from_execution;
   logic [31:0] result_from_execution;
   logic [31:0] rs2_data_from_execution;
   logic        equal_from_execution;
   logic        greater_from_execution;
   logic        lesser_from_execution;
   logic [2:0]  funct3_from_execution;
   logic [4:0]  rd_from_execution;
   logic        write_reg_from_execution;
   logic        select_from_execution;
   logic        read_from_execution;
   logic        write_from_execution;
   logic        branch_from_execution;
   logic        u_branch_from_execution;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall_from_memory;
   logic        pc_src_from_memory;
   logic [31:0] branch_target_from_memory;
   logic [31:0] result_from_memory;
   logic [31:0] mem_data_from_memory;
   logic [4:0]  rd_from_memory;
   logic        write_reg_from_memory;
   logic        select_from_memory;
   logic        misaligned_from_memory;
   logic        bus_error_from_memory;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .branch_addr_from_execution (branch_addr_from_execution),
      .result_from_execution      (result_from_execution),
      .rs2_data_from_execution    (rs2_data_from_execution),
      .equal_from_execution       (equal_from_execution),
      .greater_from_execution     (greater_from_execution),
      .lesser_from_execution      (lesser_from_execution),
      .funct3_from_execution      (funct3_from_execution),
      .rd_from_execution          (rd_from_execution),
      .write_reg_from_execution   (write_reg_from_execution),
      .select_from_execution      (select_from_execution),
      .read_from_execution        (read_from_execution),
      .write_from_execution       (write_from_execution),
      .branch_from_execution      (branch_from_execution),
      .u_branch_from_execution    (u_branch_from_execution),
      .dmem_addr                  (dmem_addr),
      .dmem_wdata                 (dmem_wdata),
      .dmem_be                    (dmem_be),
      .dmem_req                   (dmem_req),
      .dmem_we                    (dmem_we),
      .dmem_rdata                 (dmem_rdata),
      .dmem_ack                   (dmem_ack),
      .stall_from_memory          (stall_from_memory),
      .pc_src_from_memory         (pc_src_from_memory),
      .branch_target_from_memory  (branch_target_from_memory),
      .result_from_memory         (result_from_memory),
      .mem_data_from_memory       (mem_data_from_memory),
      .rd_from_memory             (rd_from_memory),
      .write_reg_from_memory      (write_reg_from_memory),
      .select_from_memory         (select_from_memory),
      .misaligned_from_memory     (misaligned_from_memory),
      .bus_error_from_memory      (bus_error_from_memory)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      branch_addr_from_execution = '0;
      result_from_execution      = '0;
      rs2_data_from_execution    = '0;
      equal_from_execution       = 1'b0;
      greater_from_execution     = 1'b0;
      lesser_from_execution      = 1'b0;
      funct3_from_execution      = '0;
      rd_from_execution          = '0;
      write_reg_from_execution   = 1'b0;
      select_from_execution      = 1'b0;
      read_from_execution        = 1'b0;
      write_from_execution       = 1'b0;
      branch_from_execution      = 1'b0;
      u_branch_from_execution    = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] f3,
                       input logic [4:0] rd);
      nop();
      result_from_execution    = a;
      funct3_from_execution    = f3;
      rd_from_execution        = rd;
      read_from_execution      = 1'b1;
      write_reg_from_execution = 1'b1;
      select_from_execution    = 1'b1;
   endtask

   initial begin
      rst        = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      nop();
      #2;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall_from_memory), 32'd0);
      chk("rst_wreg", 32'(write_reg_from_memory), 32'd0);
      chk("rst_result", result_from_memory, 32'd0);
      chk("rst_memdata", mem_data_from_memory, 32'd0);
      chk("rst_misal", 32'(misaligned_from_memory), 32'd0);
      chk("rst_buserr", 32'(bus_error_from_memory), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // LW 0x100, ack on third WAIT cycle
      load(32'h100, 3'b010, 5'd5);
      #1;
      chk("lw_stall0", 32'(stall_from_memory), 32'd1);
      chk("lw_req0", 32'(dmem_req), 32'd0);
      step();
      chk("lw_req1", 32'(dmem_req), 32'd1);
      chk("lw_stall1", 32'(stall_from_memory), 32'd1);
      chk("lw_addr", dmem_addr, 32'h100);
      chk("lw_be", 32'(dmem_be), 32'hF);
      chk("lw_we", 32'(dmem_we), 32'd0);
      chk("lw_bubble", 32'(write_reg_from_memory), 32'd0);
      step();
      chk("lw_req2", 32'(dmem_req), 32'd1);
      chk("lw_stall2", 32'(stall_from_memory), 32'd1);
      step();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      #1;
      chk("lw_req3", 32'(dmem_req), 32'd1);
      chk("lw_stall3", 32'(stall_from_memory), 32'd0);
      step();
      dmem_ack = 1'b0;
      nop();
      chk("lw_data", mem_data_from_memory, 32'hDEADBEEF);
      chk("lw_sel", 32'(select_from_memory), 32'd1);
      chk("lw_wreg", 32'(write_reg_from_memory), 32'd1);
      chk("lw_rd", 32'(rd_from_memory), 32'd5);
      chk("lw_result", result_from_memory, 32'h100);
      chk("lw_req_done", 32'(dmem_req), 32'd0);

      // LB at 0x203
      load(32'h203, 3'b000, 5'd6);
      step();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h80123456;
      step();
      dmem_ack = 1'b0;
      chk("lb_data", mem_data_from_memory, 32'hFFFFFF80);
      chk("lb_rd", 32'(rd_from_memory), 32'd6);

      // LBU at 0x203
      load(32'h203, 3'b100, 5'd7);
      step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("lbu_data", mem_data_from_memory, 32'h00000080);

      // LH at 0x202: upper half 0x8012
      load(32'h202, 3'b001, 5'd8);
      step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("lh_data", mem_data_from_memory, 32'hFFFF8012);

      // SH at 0x302
      nop();
      result_from_execution   = 32'h302;
      rs2_data_from_execution = 32'h1234ABCD;
      funct3_from_execution   = 3'b001;
      write_from_execution    = 1'b1;
      step();
      chk("sh_be", 32'(dmem_be), 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
      chk("sh_we", 32'(dmem_we), 32'd1);
      chk("sh_addr", dmem_addr, 32'h300);
      chk("sh_req", 32'(dmem_req), 32'd1);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      nop();
      chk("sh_wreg", 32'(write_reg_from_memory), 32'd0);
      #1;
      chk("sh_stall_after", 32'(stall_from_memory), 32'd0);

      // SB at 0x401
      nop();
      result_from_execution   = 32'h401;
      rs2_data_from_execution = 32'h000000A5;
      funct3_from_execution   = 3'b000;
      write_from_execution    = 1'b1;
      step();
      chk("sb_be", 32'(dmem_be), 32'h2);
      chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      nop();

      // Branches
      branch_addr_from_execution = 32'h4000;
      branch_from_execution      = 1'b1;
      funct3_from_execution      = 3'b001;
      #1;
      chk("bne_taken", 32'(pc_src_from_memory), 32'd1);
      chk("bne_target", branch_target_from_memory, 32'h4000);
      funct3_from_execution = 3'b101;
      lesser_from_execution = 1'b1;
      #1;
      chk("bge_not", 32'(pc_src_from_memory), 32'd0);
      funct3_from_execution = 3'b010;
      #1;
      chk("br_bad_f3", 32'(pc_src_from_memory), 32'd0);
      funct3_from_execution = 3'b000;
      equal_from_execution  = 1'b1;
      #1;
      chk("beq_taken", 32'(pc_src_from_memory), 32'd1);
      nop();
      u_branch_from_execution = 1'b1;
      #1;
      chk("jal_taken", 32'(pc_src_from_memory), 32'd1);
      nop();

      // Pass-through ALU op
      result_from_execution    = 32'h55AA;
      rd_from_execution        = 5'd9;
      write_reg_from_execution = 1'b1;
      #1;
      chk("alu_stall", 32'(stall_from_memory), 32'd0);
      step();
      chk("alu_result", result_from_memory, 32'h55AA);
      chk("alu_rd", 32'(rd_from_memory), 32'd9);
      chk("alu_wreg", 32'(write_reg_from_memory), 32'd1);
      chk("alu_sel", 32'(select_from_memory), 32'd0);
      chk("alu_memdata", mem_data_from_memory, 32'd0);

      // Misaligned LW at 0x102
      load(32'h102, 3'b010, 5'd3);
      #1;
      chk("mis_stall", 32'(stall_from_memory), 32'd0);
      chk("mis_req0", 32'(dmem_req), 32'd0);
      step();
      nop();
      chk("mis_pulse", 32'(misaligned_from_memory), 32'd1);
      chk("mis_wreg", 32'(write_reg_from_memory), 32'd0);
      chk("mis_req1", 32'(dmem_req), 32'd0);
      step();
      chk("mis_pulse_end", 32'(misaligned_from_memory), 32'd0);

      // Reset during WAIT, then a stray ack
      load(32'h100, 3'b010, 5'd4);
      step();
      chk("rw_req", 32'(dmem_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rw_req_drop", 32'(dmem_req), 32'd0);
      chk("rw_result", result_from_memory, 32'd0);
      chk("rw_rd", 32'(rd_from_memory), 32'd0);
      #2;
      rst = 1'b0;
      nop();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      #1;
      chk("late_ack_stall", 32'(stall_from_memory), 32'd0);
      step();
      dmem_ack = 1'b0;
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_data", mem_data_from_memory, 32'd0);
      chk("late_ack_wreg", 32'(write_reg_from_memory), 32'd0);

`ifdef MEM_TIMEOUT_EN
      begin
         int n;
         n = 0;
         load(32'h100, 3'b010, 5'd2);
         step();
         for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (bus_error_from_memory) break;
         end
         chk("to_edges", 32'(n), 32'd16);
         chk("to_buserr", 32'(bus_error_from_memory), 32'd1);
         chk("to_wreg", 32'(write_reg_from_memory), 32'd0);
         chk("to_memdata", mem_data_from_memory, 32'd0);
         nop();
         step();
         chk("to_pulse_end", 32'(bus_error_from_memory), 32'd0);
      end
`else
      load(32'h100, 3'b010, 5'd2);
      for (int i = 0; i < 20; i++) step();
      chk("no_to_req", 32'(dmem_req), 32'd1);
      chk("no_to_buserr", 32'(bus_error_from_memory), 32'd0);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      nop();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
